// File: rtl/stage2_mem_ctrl_pkg.sv
// Shared constants, width codes and FSM state type for the stage-2 memory controller.
package stage2_mem_ctrl_pkg;

   localparam logic [6:0]  OPC_LOAD         = 7'b0000011;
   localparam logic [6:0]  OPC_STORE        = 7'b0100011;
   localparam logic [1:0]  F3_BYTE          = 2'b00;
   localparam logic [1:0]  F3_HALF          = 2'b01;
   localparam logic [1:0]  F3_WORD          = 2'b10;
   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   // Reserved width code 2'b11 is treated like a word.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
      logic mis;
      case (width)
         F3_BYTE: mis = 1'b0;
         F3_HALF: mis = addr_lo[0];
         default: mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/stage2_mem_ctrl_store_align.sv
// Store alignment: byte enables, lane-shifted write data and word-aligned address.
module stage2_mem_ctrl_store_align
   import stage2_mem_ctrl_pkg::*;
(
   input  logic        is_store_i,
   input  logic [1:0]  width_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] rs2_i,
   output logic [3:0]  be_o,
   output logic [31:0] addr_o,
   output logic [31:0] wdata_o
);

   always_comb begin
      be_o = 4'b0000;
      if (is_store_i) begin
         case (width_i)
            F3_BYTE: be_o = 4'b0001 << addr_i[1:0];
            F3_HALF: be_o = 4'b0011 << {addr_i[1], 1'b0};
            default: be_o = 4'b1111;
         endcase
      end
   end

   assign wdata_o = rs2_i << {addr_i[1:0], 3'b000};
   assign addr_o  = {addr_i[31:2], 2'b00};

endmodule

// File: rtl/stage2_mem_ctrl.sv
// Stage-2 memory controller: D-cache handshake, pipeline stall and stage-3 register.
// Define STAGE2_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module stage2_mem_ctrl
   import stage2_mem_ctrl_pkg::*;
#(
   parameter logic [31:0] NOP_INST       = NOP_INST_DEFAULT,
   parameter int unsigned DCACHE_LAT_MAX = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] s2_inst,
   input  logic [31:0] s2_pc,
   input  logic [31:0] s2_alu_out,
   input  logic [31:0] s2_rs2,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] stage3_inst_in,
   output logic [31:0] stage3_pc_in,
   output logic [31:0] stage3_alu_out,
   output logic [31:0] stage3_dmem_write_addr,
   output logic [31:0] stage3_dmem_write_data,
   output logic        dcache_req_valid,
   input  logic        dcache_req_ready,
   output logic [3:0]  dcache_req_we,
   output logic [31:0] dcache_req_addr,
   output logic [31:0] dcache_req_wdata,
   input  logic        dcache_resp_valid,
   output logic        misalign_exc,
   output logic        timeout_err
);

   localparam int unsigned     CntW    = $clog2(DCACHE_LAT_MAX + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DCACHE_LAT_MAX - 1);

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic            flush_pend_q, req_store_q, timeout_q, misalign_q;
   logic [3:0]      req_we_q;
   logic [31:0]     req_addr_q, req_wdata_q;
   logic [31:0]     s3_inst_q, s3_pc_q, s3_alu_q, s3_waddr_q, s3_wdata_q;

   logic            is_load, is_store, is_mem, trap, issue, timeout_hit, done, kill;
   logic [3:0]      al_be;
   logic [31:0]     al_addr, al_wdata;

   assign is_load  = (s2_inst[6:0] == OPC_LOAD);
   assign is_store = (s2_inst[6:0] == OPC_STORE);
   assign is_mem   = is_load | is_store;

`ifdef STAGE2_MISALIGN_TRAP_EN
   assign trap = reset & (state_q == StIdle) & is_mem & ~flush &
                 is_misaligned(s2_inst[13:12], s2_alu_out[1:0]);
`else
   assign trap = 1'b0;
`endif

   // Gated by reset so nothing is requested or stalled while reset is held.
   assign issue       = reset & (state_q == StIdle) & is_mem & ~flush & ~trap;
   assign timeout_hit = (state_q == StWait) & ~dcache_resp_valid & (cnt_q == CntLast);

   always_comb begin
      done = 1'b1;
      case (state_q)
         StIdle:  done = ~issue | (dcache_req_ready & is_store);
         StReq:   done = dcache_req_ready & req_store_q;
         StWait:  done = dcache_resp_valid | timeout_hit;
         default: done = 1'b1;
      endcase
   end

   assign stall = ~done;
   assign kill  = flush | flush_pend_q | timeout_hit | trap;

   stage2_mem_ctrl_store_align u_store_align (
      .is_store_i (is_store),
      .width_i    (s2_inst[13:12]),
      .addr_i     (s2_alu_out),
      .rs2_i      (s2_rs2),
      .be_o       (al_be),
      .addr_o     (al_addr),
      .wdata_o    (al_wdata)
   );

   // Request fields are frozen in REQ so a flushed stage 2 cannot disturb the handshake.
   assign dcache_req_valid = issue | (state_q == StReq);
   assign dcache_req_we    = (state_q == StReq) ? req_we_q    : al_be;
   assign dcache_req_addr  = (state_q == StReq) ? req_addr_q  : al_addr;
   assign dcache_req_wdata = (state_q == StReq) ? req_wdata_q : al_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         req_store_q  <= 1'b0;
         timeout_q    <= 1'b0;
         misalign_q   <= 1'b0;
         req_we_q     <= '0;
         req_addr_q   <= '0;
         req_wdata_q  <= '0;
         s3_inst_q    <= NOP_INST;
         s3_pc_q      <= '0;
         s3_alu_q     <= '0;
         s3_waddr_q   <= '0;
         s3_wdata_q   <= '0;
      end else begin
         misalign_q <= trap;
         if (timeout_hit) timeout_q <= 1'b1;
         case (state_q)
            StIdle: begin
               flush_pend_q <= 1'b0;
               cnt_q        <= '0;
               if (issue) begin
                  req_we_q    <= al_be;
                  req_addr_q  <= al_addr;
                  req_wdata_q <= al_wdata;
                  req_store_q <= is_store;
                  if (!dcache_req_ready) state_q <= StReq;
                  else if (is_load)      state_q <= StWait;
               end
            end
            StReq: begin
               flush_pend_q <= (flush_pend_q | flush) & ~done;
               if (dcache_req_ready) state_q <= req_store_q ? StIdle : StWait;
            end
            StWait: begin
               flush_pend_q <= (flush_pend_q | flush) & ~done;
               if (done) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
         if (!stall) begin
            s3_inst_q  <= kill ? NOP_INST : s2_inst;
            s3_pc_q    <= s2_pc;
            s3_alu_q   <= s2_alu_out;
            s3_waddr_q <= al_addr;
            s3_wdata_q <= al_wdata;
         end
      end
   end

   assign stage3_inst_in         = s3_inst_q;
   assign stage3_pc_in           = s3_pc_q;
   assign stage3_alu_out         = s3_alu_q;
   assign stage3_dmem_write_addr = s3_waddr_q;
   assign stage3_dmem_write_data = s3_wdata_q;
   assign misalign_exc           = misalign_q;
   assign timeout_err            = timeout_q;

endmodule

// File: tb/tb_stage2_mem_ctrl.sv
// Bench for stage2_mem_ctrl: directed and random instructions against a transaction-level model.
module tb_stage2_mem_ctrl;

   localparam logic [31:0] Nop    = 32'h0000_0013;
   localparam int          LatMax = 16;
`ifdef STAGE2_MISALIGN_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] s2_inst, s2_pc, s2_alu_out, s2_rs2;
   logic        flush, stall;
   logic [31:0] stage3_inst_in, stage3_pc_in, stage3_alu_out;
   logic [31:0] stage3_dmem_write_addr, stage3_dmem_write_data;
   logic        dcache_req_valid, dcache_req_ready, dcache_resp_valid;
   logic [3:0]  dcache_req_we;
   logic [31:0] dcache_req_addr, dcache_req_wdata;
   logic        misalign_exc, timeout_err;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_inst = Nop;
   logic        exp_te   = 1'b0;
   logic [6:0]  nonmem [4] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111};
   logic [31:0] add_x1 = 32'h0020_80B3;

   always #5 clk = ~clk;

   stage2_mem_ctrl #(.NOP_INST(Nop), .DCACHE_LAT_MAX(LatMax)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .s2_inst                (s2_inst),
      .s2_pc                  (s2_pc),
      .s2_alu_out             (s2_alu_out),
      .s2_rs2                 (s2_rs2),
      .flush                  (flush),
      .stall                  (stall),
      .stage3_inst_in         (stage3_inst_in),
      .stage3_pc_in           (stage3_pc_in),
      .stage3_alu_out         (stage3_alu_out),
      .stage3_dmem_write_addr (stage3_dmem_write_addr),
      .stage3_dmem_write_data (stage3_dmem_write_data),
      .dcache_req_valid       (dcache_req_valid),
      .dcache_req_ready       (dcache_req_ready),
      .dcache_req_we          (dcache_req_we),
      .dcache_req_addr        (dcache_req_addr),
      .dcache_req_wdata       (dcache_req_wdata),
      .dcache_resp_valid      (dcache_resp_valid),
      .misalign_exc           (misalign_exc),
      .timeout_err            (timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
      logic [31:0] r;
      r       = $urandom;
      r[6:0]  = opc;
      r[14:12] = f3;
      return r;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_inst"},  stage3_inst_in, Nop);
      chk({tag, "_pc"},    stage3_pc_in, 32'd0);
      chk({tag, "_alu"},   stage3_alu_out, 32'd0);
      chk({tag, "_waddr"}, stage3_dmem_write_addr, 32'd0);
      chk({tag, "_wdata"}, stage3_dmem_write_data, 32'd0);
      chk({tag, "_valid"}, 32'(dcache_req_valid), 32'd0);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_mis"},   32'(misalign_exc), 32'd0);
      chk({tag, "_te"},    32'(timeout_err), 32'd0);
   endtask

   // One stage-2 instruction from presentation to retirement. r = cycle of ready, d = cycles
   // from acceptance to response (loads), f = flush cycle or -1. Called at posedge + 1.
   task automatic do_inst(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] rs2, input int r, input int d, input int f);
      bit is_ld  = (inst[6:0] == OpLoad);
      bit is_st  = (inst[6:0] == OpStore);
      bit mem    = is_ld | is_st;
      int w      = int'(inst[13:12]);
      int lo     = int'(alu[1:0]);
      bit mis    = (w == 1) ? (lo % 2 == 1) : (w >= 2 && lo != 0);
      int lat    = (d > LatMax) ? LatMax : d;
      int ret_if = is_st ? r : r + lat;
      bit trap, issued, tmo, killed;
      int ret, nstall;
      logic [3:0]  exp_be;
      logic [31:0] exp_addr  = alu & 32'hFFFF_FFFC;
      logic [31:0] exp_wdata = rs2 << (8 * lo);

      if (!mem || f > ret_if) f = -1;
      trap   = TrapEn && mem && mis && f != 0;
      issued = mem && f != 0 && !trap;
      ret    = issued ? ret_if : 0;
      tmo    = issued && is_ld && d > LatMax;
      killed = (f >= 0) || tmo || trap;
      if (!is_st)      exp_be = 4'b0000;
      else if (w == 0) exp_be = 4'b0001 << lo;
      else if (w == 1) exp_be = 4'b0011 << (lo & 2);
      else             exp_be = 4'b1111;

      s2_inst    = inst;
      s2_pc      = pc;
      s2_alu_out = alu;
      s2_rs2     = rs2;
      nstall     = 0;
      for (int k = 0; k <= ret; k++) begin
         flush             = (k == f);
         dcache_req_ready  = issued && (k == r);
         dcache_resp_valid = issued && is_ld && (k == r + d);
         #1;
         if (stall) nstall++;
         chk("stall", 32'(stall), 32'(k < ret));
         chk("req_valid", 32'(dcache_req_valid), 32'(issued && k <= r));
         if (issued && k <= r) begin
            chk("req_we", 32'(dcache_req_we), 32'(exp_be));
            chk("req_addr", dcache_req_addr, exp_addr);
            chk("req_wdata", dcache_req_wdata, exp_wdata);
         end
         @(posedge clk);
         #1;
         if (k == ret) begin
            exp_inst = killed ? Nop : inst;
            exp_te   = exp_te | tmo;
            chk("s3_inst", stage3_inst_in, exp_inst);
            chk("s3_pc", stage3_pc_in, pc);
            chk("s3_alu", stage3_alu_out, alu);
            chk("s3_waddr", stage3_dmem_write_addr, exp_addr);
            chk("s3_wdata", stage3_dmem_write_data, exp_wdata);
            chk("timeout_err", 32'(timeout_err), 32'(exp_te));
            chk("misalign_exc", 32'(misalign_exc), 32'(trap));
         end else begin
            chk("s3_hold", stage3_inst_in, exp_inst);
            chk("misalign_idle", 32'(misalign_exc), 32'd0);
         end
      end
      chk("stall_cycles", 32'(nstall), 32'(ret));
      flush             = 1'b0;
      dcache_req_ready  = 1'b0;
      dcache_resp_valid = 1'b0;
   endtask

   initial begin
      int kind, r, d, f;
      logic [6:0] opc;

      reset = 1'b0;
      s2_inst = '0; s2_pc = '0; s2_alu_out = '0; s2_rs2 = '0;
      flush = 1'b0; dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Non-memory op, byte store into top lane, delayed load, flushes.
      do_inst(add_x1, 32'h0000_0400, 32'h1234_5678, 32'h0, 0, 1, -1);
      do_inst(mk_inst(OpStore, 3'b000), 32'h404, 32'h0000_1003, 32'h0000_00AB, 0, 1, -1);
      do_inst(mk_inst(OpLoad, 3'b010), 32'h408, 32'h0000_0100, 32'h0, 2, 3, -1);
      do_inst(mk_inst(OpLoad, 3'b010), 32'h40C, 32'h0000_0100, 32'h0, 0, 4, 2);
      do_inst(mk_inst(OpStore, 3'b001), 32'h410, 32'h0000_2002, 32'hCAFE_BEEF, 3, 1, 1);
      do_inst(mk_inst(OpLoad, 3'b000), 32'h414, 32'h0000_3001, 32'h0, 1, 2, 3);
      do_inst(mk_inst(OpStore, 3'b010), 32'h418, 32'h0000_4000, 32'h1111_2222, 0, 1, 0);
      do_inst(mk_inst(OpLoad, 3'b010), 32'h41C, 32'h0000_0102, 32'h0, 0, 1, -1);
      do_inst(mk_inst(OpStore, 3'b010), 32'h420, 32'h0000_5001, 32'hA5A5_5A5A, 1, 1, -1);
      do_inst(mk_inst(OpLoad, 3'b010), 32'h424, 32'h0000_6000, 32'h0, 1, LatMax, -1);

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0)      opc = nonmem[$urandom_range(0, 3)];
         else if (kind == 1) opc = OpLoad;
         else                opc = OpStore;
         r = $urandom_range(0, 3);
         d = $urandom_range(1, 6);
         f = ($urandom_range(0, 4) == 0) ? $urandom_range(0, r + d) : -1;
         do_inst(mk_inst(opc, 3'($urandom_range(0, 2))), $urandom, $urandom, $urandom, r, d, f);
      end

      // No response: timeout retires a NOP and leaves the controller idle.
      do_inst(mk_inst(OpLoad, 3'b010), 32'h500, 32'h0000_7000, 32'h0, 0, 100, -1);
      do_inst(add_x1, 32'h504, 32'h0, 32'h0, 0, 1, -1);
      do_inst(mk_inst(OpLoad, 3'b010), 32'h508, 32'h0000_7004, 32'h0, 0, 2, -1);

      // Reset while waiting for a load response; the late response must be ignored.
      s2_inst = mk_inst(OpLoad, 3'b010); s2_alu_out = 32'h200; s2_pc = 32'h600;
      dcache_req_ready = 1'b1;
      #1;
      chk("rst_pre_valid", 32'(dcache_req_valid), 32'd1);
      @(posedge clk);
      #1;
      dcache_req_ready = 1'b0;
      chk("rst_pre_stall", 32'(stall), 32'd1);
      #2 reset = 1'b0;
      #1;
      exp_inst = Nop;
      exp_te   = 1'b0;
      chk_reset_outputs("midrst");
      @(posedge clk);
      #1;
      s2_inst = add_x1; s2_pc = 32'h604;
      reset = 1'b1;
      dcache_resp_valid = 1'b1;
      #1;
      chk("late_resp_stall", 32'(stall), 32'd0);
      chk("late_resp_valid", 32'(dcache_req_valid), 32'd0);
      @(posedge clk);
      #1;
      dcache_resp_valid = 1'b0;
      exp_inst = add_x1;
      chk("late_resp_s3", stage3_inst_in, exp_inst);
      do_inst(mk_inst(OpStore, 3'b001), 32'h608, 32'h0000_8006, 32'h0000_BEEF, 1, 1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stage2_mem_ctrl.md
STAGE2_MEM_CTRL -- requirements
Module: stage2_mem_ctrl

Interface
REQ-001 Parameter NOP_INST, default 32'h00000013, SHALL be the instruction loaded into stage 3 on reset, flush or dropped access.
REQ-002 Parameter DCACHE_LAT_MAX, default 16, SHALL be the maximum response wait in cycles before timeout_err asserts.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 s2_inst, s2_pc, s2_alu_out, s2_rs2  input  32 each  stage-2 instruction, PC, ALU result (memory address), store source.
REQ-006 flush  input  1  kill the stage-2 instruction.
REQ-007 stall  output  1  freeze stages 1-2 this cycle.
REQ-008 stage3_inst_in, stage3_pc_in, stage3_alu_out, stage3_dmem_write_addr, stage3_dmem_write_data  output  32 each  registered stage-3 inputs.
REQ-009 dcache_req_valid  output 1; dcache_req_ready  input 1; dcache_req_we  output 4 (byte enables, 0 = load); dcache_req_addr, dcache_req_wdata  output 32; dcache_resp_valid  input 1.
REQ-010 misalign_exc  output  1  one-cycle pulse on misaligned access; timeout_err  output 1  sticky error.

Function
REQ-011 Memory op SHALL be opcode 0000011 (load) or 0100011 (store) of s2_inst; width from funct3[1:0] (00 byte, 01 half, 10 word).
REQ-012 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b0000.
REQ-013 dcache_req_wdata SHALL be s2_rs2 shifted left by 8*addr[1:0]; dcache_req_addr = s2_alu_out with bits[1:0] zeroed.
REQ-014 FSM states IDLE, REQ, WAIT, each transition on clock edge.
REQ-015 IDLE: memory op and not flush -> assert dcache_req_valid; ready same cycle: store -> IDLE, load -> WAIT; not ready -> REQ.
REQ-016 REQ: hold valid, addr, wdata, we stable until ready; then store -> IDLE, load -> WAIT.
REQ-017 WAIT: on dcache_resp_valid -> IDLE; counter increments each WAIT cycle, reaching DCACHE_LAT_MAX sets timeout_err and returns to IDLE with NOP inserted.
REQ-018 stall = memory op pending and not completing this cycle (IDLE with op and not accepted-store, REQ, WAIT without resp_valid).
REQ-019 Stage-3 registers SHALL load s2 values on every edge with stall low; hold when stall high.
REQ-020 Non-memory instruction: latency 1 cycle, no stall; accepted store: 1 cycle; load with ready at cycle 0 and resp at cycle N: stall cycles 0..N-1.
REQ-021 flush in IDLE SHALL prevent the request and load NOP_INST; flush in REQ/WAIT SHALL latch flush_pending, complete the handshake (valid never retracted) and load NOP_INST on completion.
REQ-022 flush and resp_valid in same WAIT cycle SHALL load NOP_INST and return IDLE.

Reset
REQ-023 Asserted reset: state IDLE, counter 0, stage3_inst_in = NOP_INST, all other stage-3 outputs 0, dcache_req_valid 0, stall 0, misalign_exc 0, timeout_err 0.
REQ-024 Reset mid-handshake SHALL abandon the access; an in-flight resp_valid after release SHALL be ignored in IDLE.

Configuration
REQ-025 Macro STAGE2_MISALIGN_TRAP_EN defined: half at addr[0]=1 or word at addr[1:0]!=0 SHALL not issue, pulse misalign_exc, load NOP_INST, no stall.
REQ-026 Macro undefined: misaligned accesses issue with REQ-012/013 masks unchanged; misalign_exc tied 0.

Structure
REQ-027 Shared package SHALL hold opcode constants, funct3 width codes, FSM state enum, NOP_INST value.
REQ-028 One sub-module, store_align, SHALL compute byte enables and shifted write data combinationally.

Verification
REQ-029 ADD x1 with no stall -> stage3_inst_in equals it next edge, stall 0.
REQ-030 SB addr 0x1003, rs2 0xAB, ready=1 -> we 4'b1000, wdata 0xAB000000, stall 0.
REQ-031 LW addr 0x100, ready after 2 cycles, resp 3 cycles later -> stall 5 cycles, then stage-3 update.
REQ-032 flush during WAIT -> valid held, stage3_inst_in = 0x00000013 after resp.
REQ-033 With STAGE2_MISALIGN_TRAP_EN, LW addr 0x102 -> no dcache_req_valid, misalign_exc one cycle.
REQ-034 No resp for 16 WAIT cycles -> timeout_err 1, state IDLE, stall 0.
